// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: I2S / left-justified stereo transmitter with a one-frame holding buffer
// Ports: mclk, rst (sync, active high); en transmit enable; mode 0=I2S 1=left-justified;
//        s_data_l, s_data_r, s_valid, s_ready frame handshake; sclk, ws, sd_tx serial outputs;
//        underrun one-mclk pulse when a frame starts with the buffer empty.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt, a saturating 16-bit underrun counter.
module i2s_tx_stream #(
  parameter int WIDTH = 16,
  parameter int SLOT_BITS = 32,
  parameter int MCLK_PER_SCLK = 24
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] s_data_l,
  input  logic [WIDTH-1:0] s_data_r,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             sclk,
  output logic             ws,
  output logic             sd_tx,
  output logic             underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);
  localparam int HALF = MCLK_PER_SCLK / 2;
  localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int FW = 2 * SLOT_BITS;
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_BITS);
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] b_q, b_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic sclk_q, sclk_d, started_q, started_d, mode_q, mode_d, prev_q, prev_d;
  logic ws_q, ws_d, sd_q, sd_d, under_q, under_d, full_q, full_d, rdy_q, rdy_d;
  logic tc, fall, start, accept, lj;
  logic [SLOT_BITS-1:0] slot_l, slot_r;
  assign slot_l = SLOT_BITS'(buf_l_q) << (SLOT_BITS - WIDTH);
  assign slot_r = SLOT_BITS'(buf_r_q) << (SLOT_BITS - WIDTH);
  always_comb begin
    tc = en && div_q == DIV_LAST;
    fall = tc && sclk_q;
    // the first falling event after reset/enable is a frame start, later ones only on wrap
    start = fall && (!started_q || b_q == B_LAST);
    accept = s_valid && rdy_q;
    div_d = (!en || tc) ? '0 : div_q + DW'(1);
    sclk_d = en && (tc ? !sclk_q : sclk_q);
    started_d = en && (started_q || fall);
    b_d = !en ? '0 : (!fall || !started_q) ? b_q : (b_q == B_LAST) ? '0 : b_q + BW'(1);
    // the frame is kept as one left-justified image; its MSB is the LJ bit of the current index
    sh_d = !en ? '0 : start ? (full_q ? {slot_l, slot_r} : '0) : fall ? sh_q << 1 : sh_q;
    mode_d = start ? mode : mode_q;
    lj = sh_d[FW-1];
    prev_d = en && (fall ? lj : prev_q);
    ws_d = en && (fall ? (b_d >= B_SLOT) : ws_q);
    sd_d = en && (fall ? (mode_d ? lj : prev_q) : sd_q);
    under_d = start && !full_q;
    full_d = accept || (full_q && !start);
    rdy_d = !full_d;
    buf_l_d = accept ? s_data_l : buf_l_q;
    buf_r_d = accept ? s_data_r : buf_r_q;
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      div_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      sclk_q <= 1'b0;
      started_q <= 1'b0;
      mode_q <= 1'b1;
      prev_q <= 1'b0;
      ws_q <= 1'b0;
      sd_q <= 1'b0;
      under_q <= 1'b0;
      full_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      div_q <= div_d;
      b_q <= b_d;
      sh_q <= sh_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      sclk_q <= sclk_d;
      started_q <= started_d;
      mode_q <= mode_d;
      prev_q <= prev_d;
      ws_q <= ws_d;
      sd_q <= sd_d;
      under_q <= under_d;
      full_q <= full_d;
      rdy_q <= rdy_d;
    end
  end
  assign s_ready = rdy_q;
  assign sclk = sclk_q;
  assign ws = ws_q;
  assign sd_tx = sd_q;
  assign underrun = under_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (under_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge mclk) cnt_q <= rst ? '0 : cnt_d;
  assign underrun_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_i2s_tx_stream.sv
// tb_i2s_tx_stream: directed frame vectors and corner sequences for i2s_tx_stream
module tb_i2s_tx_stream;
  localparam int MP = 24;
  typedef struct {
    logic        mode;
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] exp;
  } vec_t;
  logic mclk, rst, en, mode, s_valid, s_ready, sclk, ws, sd_tx, underrun;
  logic [15:0] s_data_l, s_data_r;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int rdy_n, und_n;
  logic [31:0] feed_q[$];
  vec_t tbl[6];
  i2s_tx_stream dut (
    .mclk(mclk), .rst(rst), .en(en), .mode(mode),
    .s_data_l(s_data_l), .s_data_r(s_data_r), .s_valid(s_valid), .s_ready(s_ready),
    .sclk(sclk), .ws(ws), .sd_tx(sd_tx), .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic next_fall(output int per, output int hi, output logic wsbad, output logic tmo);
    logic p, w0;
    per = 0;
    hi = 0;
    wsbad = 1'b0;
    w0 = ws;
    do begin
      p = sclk;
      tick();
      per++;
      if (sclk) hi++;
      if (s_ready) rdy_n++;
      if (underrun) und_n++;
      if (!(p && !sclk) && ws !== w0) wsbad = 1'b1;
    end while (!(p && !sclk) && per < 100);
    tmo = !(p && !sclk);
  endtask
  task automatic capture(input int n, output logic [63:0] sdv, output logic [63:0] wsv,
                         output logic [63:0] unv, output int bad);
    int per, hi;
    logic wb, tm;
    sdv = '0;
    wsv = '0;
    unv = '0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      next_fall(per, hi, wb, tm);
      if (per != MP || hi != MP / 2 || wb || tm) bad++;
      sdv = {sdv[62:0], sd_tx};
      wsv = {wsv[62:0], ws};
      unv = {unv[62:0], underrun};
    end
  endtask
  initial begin
    logic [31:0] f;
    s_valid = 1'b0;
    s_data_l = '0;
    s_data_r = '0;
    forever begin
      if (feed_q.size() == 0) begin
        s_valid = 1'b0;
        tick();
      end else begin
        f = feed_q.pop_front();
        s_data_l = f[31:16];
        s_data_r = f[15:0];
        s_valid = 1'b1;
        @(negedge mclk);
        for (int k = 0; k < 20000 && (!s_ready || rst); k++) @(negedge mclk);
        tick();
      end
    end
  end
  initial begin
    logic [63:0] sdv, wsv, unv;
    int bad;
    tbl[0] = '{1'b1, 16'hA5C3, 16'h8001, 64'hA5C3_0000_8001_0000};
    tbl[1] = '{1'b0, 16'hA5C3, 16'h8001, 64'h52E1_8000_4000_8000};
    tbl[2] = '{1'b1, 16'hFFFF, 16'h0000, 64'hFFFF_0000_0000_0000};
    tbl[3] = '{1'b0, 16'h0001, 16'hFFFF, 64'h0000_8000_7FFF_8000};
    tbl[4] = '{1'b1, 16'h1234, 16'hABCD, 64'h1234_0000_ABCD_0000};
    tbl[5] = '{1'b0, 16'h8000, 16'h0001, 64'h4000_0000_0000_8000};
    rst = 1'b1;
    en = 1'b0;
    mode = 1'b1;
    tick();
    tick();
    check("reset sclk", sclk, 0);
    check("reset ws", ws, 0);
    check("reset sd_tx", sd_tx, 0);
    check("reset underrun", underrun, 0);
    check("reset s_ready", s_ready, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("reset underrun_cnt", underrun_cnt, 0);
`endif
    rst = 1'b0;
    tick();
    check("s_ready after reset", s_ready, 1);
    foreach (tbl[i]) feed_q.push_back({tbl[i].l, tbl[i].r});
    repeat (4) tick();
    check("s_ready drops after accept", s_ready, 0);
    mode = tbl[0].mode;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdy_n = 0;
      und_n = 0;
      capture(64, sdv, wsv, unv, bad);
      check($sformatf("frame%0d sd_tx", i), sdv, tbl[i].exp);
      check($sformatf("frame%0d ws", i), wsv, 64'h0000_0000_FFFF_FFFF);
      check($sformatf("frame%0d underrun", i), und_n, 0);
      check($sformatf("frame%0d timing", i), bad, 0);
      if (i <= 4) check($sformatf("frame%0d s_ready cycles", i), rdy_n, 1);
      if (i < 5) mode = tbl[i+1].mode;
    end
    for (int i = 0; i < 3; i++) begin
      und_n = 0;
      capture(64, sdv, wsv, unv, bad);
      check($sformatf("empty%0d sd_tx", i), sdv, 0);
      check($sformatf("empty%0d underrun at b0", i), unv, 64'h8000_0000_0000_0000);
      check($sformatf("empty%0d underrun cycles", i), und_n, 1);
      check($sformatf("empty%0d timing", i), bad, 0);
    end
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt after 3", underrun_cnt, 3);
`endif
    mode = 1'b1;
    feed_q.push_back({16'h0000, 16'hFFFF});
    capture(41, sdv, wsv, unv, bad);
    check("pre-rst sd_tx b40", sdv[0], 1);
    check("pre-rst ws b40", wsv[0], 1);
    check("pre-rst underrun", unv, 0);
    repeat (12) tick();
    check("pre-rst sclk high", sclk, 1);
    rst = 1'b1;
    tick();
    check("mid-rst sclk", sclk, 0);
    check("mid-rst ws", ws, 0);
    check("mid-rst sd_tx", sd_tx, 0);
    check("mid-rst s_ready", s_ready, 0);
    feed_q.push_back({16'h0F0F, 16'hC003});
    tick();
    rst = 1'b0;
    und_n = 0;
    capture(64, sdv, wsv, unv, bad);
    check("post-rst sd_tx", sdv, 64'h0F0F_0000_C003_0000);
    check("post-rst ws", wsv, 64'h0000_0000_FFFF_FFFF);
    check("post-rst underrun", und_n, 0);
    check("post-rst timing", bad, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt after rst", underrun_cnt, 0);
`endif
    repeat (15) tick();
    check("pre-disable sclk", sclk, 1);
    check("pre-disable ws", ws, 1);
    en = 1'b0;
    tick();
    check("disable sclk", sclk, 0);
    check("disable ws", ws, 0);
    mode = 1'b0;
    feed_q.push_back({16'h8001, 16'h7FFE});
    repeat (4) tick();
    check("accept while disabled", s_ready, 0);
    repeat (30) tick();
    check("sclk idle while disabled", sclk, 0);
    en = 1'b1;
    und_n = 0;
    capture(64, sdv, wsv, unv, bad);
    check("re-enable sd_tx", sdv, 64'h4000_8000_3FFF_0000);
    check("re-enable ws", wsv, 64'h0000_0000_FFFF_FFFF);
    check("re-enable underrun", und_n, 0);
    check("re-enable timing", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_tx_stream.md
Name: i2s_tx_stream

Overview:
- Next-generation I2S transmitter for the CS5344-class audio path.
- Generates sclk and ws from mclk, and serialises one stereo frame per ws period.
- Generalised sample width and slot width; selectable I2S (Philips) or left-justified framing.
- Accepts frames through a valid/ready handshake with a one-frame holding buffer, and reports underrun.

Parameters:
- WIDTH, 16: sample bits per channel (>=2).
- SLOT_BITS, 32: sclk periods per channel slot (>=WIDTH); ws period = 2*SLOT_BITS sclk.
- MCLK_PER_SCLK, 24: mclk cycles per sclk period (even, >=4).

Ports:
- mclk  in  1  main clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  transmit enable.
- mode  in  1  0 = I2S (one-bit delay), 1 = left-justified.
- s_data_l  in  WIDTH  left sample, two's complement.
- s_data_r  in  WIDTH  right sample.
- s_valid  in  1  frame valid.
- s_ready  out  1  holding buffer can accept a frame.
- sclk  out  1  serial bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sd_tx  out  1  serial data, MSB first.
- underrun  out  1  one-mclk pulse: frame started with no buffered data.

Behaviour:
- Reset: sclk=0, ws=0, sd_tx=0, underrun=0, s_ready=0, holding buffer empty, all counters 0, latched mode=1.
- s_ready is registered. It goes to 1 on the first cycle after rst falls. rst mid-frame aborts the frame immediately; no partial state survives.
- Clock generation (en=1):
  - Divider counts 0..MCLK_PER_SCLK/2-1. On the terminal count, sclk toggles.
  - A "falling event" is the toggle 1->0. It is the only point where ws, sd_tx and the bit index change.
- Bit index b:
  - Counts 0..2*SLOT_BITS-1 and wraps; it advances on each falling event.
  - The first falling event after reset/enable is b=0, the frame start.
  - Before the first frame start: ws=0, sd_tx=0.
- ws = (b >= SLOT_BITS), in both modes.
- Left-justified bit for index b:
  - p = b mod SLOT_BITS.
  - The bit is sample[WIDTH-1-p] of the slot's channel when p < WIDTH, otherwise 0.
- Data output by mode:
  - Left-justified: sd_tx = LJ bit(b).
  - I2S: sd_tx = LJ bit of the previous falling event. Index b=0 therefore carries the previous frame's bit 2*SLOT_BITS-1; this is 0 when SLOT_BITS>WIDTH, and right LSB when equal. Before the first frame this bit is 0.
  - mode is latched only at frame start.
- Handshake and frame load:
  - A frame is accepted on a cycle where s_valid && s_ready; s_ready drops the next cycle.
  - At frame start, if the buffer is full, it is moved to the shift register and the buffer is freed; s_ready=1 the next cycle.
  - At frame start, if the buffer is empty, an all-zero frame is sent and underrun=1 for that cycle.
  - A frame accepted in the same cycle as frame start is not used for that frame; it stays buffered, and underrun still fires if the buffer was empty.
- Enable:
  - en=0 immediately (next cycle) zeroes the divider, b, sclk, ws and sd_tx, and discards the in-flight shift register.
  - The holding buffer and s_ready handshake stay live while en=0.
  - en 0->1 restarts as after reset. The first frame start is at the first falling event, MCLK_PER_SCLK mclk cycles after en rises.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_CNT_EN.
- Defined: adds output port underrun_cnt [15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and is cleared only by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, en=1, frames always valid -> sclk period 24 mclk (12 high/12 low); ws period 64 sclk; ws toggles only on sclk falling edges.
- mode=1, L=16'hA5C3, R=16'h8001 -> left slot bits 0-15 = A5C3 MSB-first, then 16 zeros; right slot = 8001, then zeros; no underrun.
- mode=0, same frame -> every sd_tx bit is one sclk later than in LJ; ws edge precedes the left MSB by one sclk; bit at b=0 = 0.
- s_valid held 0 after one frame -> second frame all zeros; one underrun pulse per frame start (counter reaches 3 after 3 empty frames when the macro is enabled).
- Back-pressure: s_valid=1 continuously -> s_ready high exactly one cycle per frame, one frame accepted per frame start, no lost or repeated frame.
- rst asserted mid right slot -> next cycle sclk=0, ws=0, sd_tx=0, s_ready=0; after release, the first frame starts at a falling event with b=0 and sends the newly accepted data.
